// File: rtl/mc_control_if.sv
// Handshake/control bundle between the decode stage, datapath and mc_control.
// i_target exists only when MC_CONTROL_BEX_SETX_EN is defined.
interface mc_control_if #(
  parameter int OPCODE_W = 5,
  parameter int ALUOP_W  = 5,
  parameter int STATUS_W = 32,
  parameter int TARGET_W = 27
);
  logic                i_instr_valid;
  logic [OPCODE_W-1:0] i_opcode;
  logic [ALUOP_W-1:0]  i_aluop;
  logic                i_alu_ovf;
  logic                i_alu_ne;
  logic                i_alu_lt;
  logic                i_md_ready;
  logic                i_md_exception;
`ifdef MC_CONTROL_BEX_SETX_EN
  logic [TARGET_W-1:0] i_target;
`endif
  logic                o_instr_ready;
  logic                o_rwe;
  logic [1:0]          o_dest_sel;
  logic [1:0]          o_val_sel;
  logic                o_alu_sei;
  logic [ALUOP_W-1:0]  o_alu_op_out;
  logic                o_dmwe;
  logic [1:0]          o_pc_sel;
  logic                o_pc_en;
  logic                o_md_mult;
  logic                o_md_div;
  logic [STATUS_W-1:0] o_status_val;

  modport slave (
`ifdef MC_CONTROL_BEX_SETX_EN
    input  i_target,
`endif
    input  i_instr_valid, i_opcode, i_aluop, i_alu_ovf, i_alu_ne, i_alu_lt,
           i_md_ready, i_md_exception,
    output o_instr_ready, o_rwe, o_dest_sel, o_val_sel, o_alu_sei, o_alu_op_out,
           o_dmwe, o_pc_sel, o_pc_en, o_md_mult, o_md_div, o_status_val
  );

  modport master (
`ifdef MC_CONTROL_BEX_SETX_EN
    output i_target,
`endif
    output i_instr_valid, i_opcode, i_aluop, i_alu_ovf, i_alu_ne, i_alu_lt,
           i_md_ready, i_md_exception,
    input  o_instr_ready, o_rwe, o_dest_sel, o_val_sel, o_alu_sei, o_alu_op_out,
           o_dmwe, o_pc_sel, o_pc_en, o_md_mult, o_md_div, o_status_val
  );
endinterface

// File: rtl/mc_control.sv
// Multicycle control: registered decode, mult/div sequencing with timeout/exception.
// Optional setx/bex decode is enabled by defining MC_CONTROL_BEX_SETX_EN.
module mc_control #(
  parameter int OPCODE_W   = 5,
  parameter int ALUOP_W    = 5,
  parameter int STATUS_W   = 32,
  parameter int MD_TIMEOUT = 40
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mc_control_if.slave   bus
);
  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(8);
`ifdef MC_CONTROL_BEX_SETX_EN
  localparam logic [OPCODE_W-1:0] OP_SETX = OPCODE_W'(21);
  localparam logic [OPCODE_W-1:0] OP_BEX  = OPCODE_W'(22);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MD_START, S_MD_WAIT, S_MD_WB
  } state_t;

  state_t r_state, w_state;

  logic                r_ready, w_ready;
  logic                r_rwe, w_rwe;
  logic [1:0]          r_dest_sel, w_dest_sel;
  logic [1:0]          r_val_sel, w_val_sel;
  logic                r_alu_sei, w_alu_sei;
  logic [ALUOP_W-1:0]  r_alu_op, w_alu_op;
  logic                r_dmwe, w_dmwe;
  logic [1:0]          r_pc_sel, w_pc_sel;
  logic                r_pc_en, w_pc_en;
  logic                r_md_mult, w_md_mult;
  logic                r_md_div, w_md_div;
  logic [STATUS_W-1:0] r_status, w_status;
  // Overflow code doubles as the status value: 1 add, 2 addi, 3 sub, 0 none.
  logic [1:0]          r_ovf_code, w_ovf_code;
  logic                r_br_ne, w_br_ne;
  logic                r_br_lt, w_br_lt;
  logic                r_is_mul, w_is_mul;
  logic [CNT_W-1:0]    r_cnt, w_cnt, w_cnt_inc;
`ifdef MC_CONTROL_BEX_SETX_EN
  logic                r_bex, w_bex;
`endif

  logic w_accept, w_is_md, w_timeout, w_exc;
  logic w_in_exec, w_ovf, w_br_taken, w_bex_taken;

  assign w_accept  = bus.i_instr_valid & r_ready;
  assign w_is_md   = (bus.i_opcode == OP_R) &&
                     ((bus.i_aluop == ALUOP_W'(6)) || (bus.i_aluop == ALUOP_W'(7)));
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == CNT_W'(MD_TIMEOUT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state;
  end

  always_comb begin
    w_state    = r_state;
    w_rwe      = 1'b0;
    w_dest_sel = 2'b00;
    w_val_sel  = 2'b00;
    w_alu_sei  = 1'b0;
    w_alu_op   = '0;
    w_dmwe     = 1'b0;
    w_pc_sel   = 2'b00;
    w_pc_en    = 1'b0;
    w_md_mult  = 1'b0;
    w_md_div   = 1'b0;
    w_status   = '0;
    w_ovf_code = 2'd0;
    w_br_ne    = 1'b0;
    w_br_lt    = 1'b0;
    w_is_mul   = r_is_mul;
    w_cnt      = '0;
    w_exc      = 1'b0;
`ifdef MC_CONTROL_BEX_SETX_EN
    w_bex      = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_EXEC: begin
        if (!w_accept) begin
          w_state = S_IDLE;
        end else if (w_is_md) begin
          w_state   = S_MD_START;
          w_is_mul  = (bus.i_aluop == ALUOP_W'(6));
          w_md_mult = w_is_mul;
          w_md_div  = !w_is_mul;
        end else begin
          w_state = S_EXEC;
          w_pc_en = 1'b1;
          case (bus.i_opcode)
            OP_R: begin
              w_rwe    = 1'b1;
              w_alu_op = bus.i_aluop;
              if (bus.i_aluop == ALUOP_W'(0))      w_ovf_code = 2'd1;
              else if (bus.i_aluop == ALUOP_W'(1)) w_ovf_code = 2'd3;
            end
            OP_J:    w_pc_sel = 2'b10;
            OP_BNE:  w_br_ne  = 1'b1;
            OP_JAL: begin
              w_rwe      = 1'b1;
              w_dest_sel = 2'b01;
              w_val_sel  = 2'b10;
              w_pc_sel   = 2'b10;
            end
            OP_JR:   w_pc_sel = 2'b11;
            OP_ADDI: begin
              w_rwe      = 1'b1;
              w_alu_sei  = 1'b1;
              w_ovf_code = 2'd2;
            end
            OP_BLT:  w_br_lt  = 1'b1;
            OP_SW: begin
              w_alu_sei = 1'b1;
              w_dmwe    = 1'b1;
            end
            OP_LW: begin
              w_rwe     = 1'b1;
              w_val_sel = 2'b01;
              w_alu_sei = 1'b1;
            end
`ifdef MC_CONTROL_BEX_SETX_EN
            OP_SETX: begin
              w_rwe      = 1'b1;
              w_dest_sel = 2'b10;
              w_val_sel  = 2'b10;
              w_status   = STATUS_W'(bus.i_target);
            end
            OP_BEX:  w_bex = 1'b1;
`endif
            default: ;
          endcase
        end
      end
      S_MD_START: w_state = S_MD_WAIT;
      S_MD_WAIT: begin
        w_cnt = w_cnt_inc;
        // A result arriving on the timeout cycle takes priority over the forced exception.
        if (bus.i_md_ready || w_timeout) begin
          w_state   = S_MD_WB;
          w_exc     = bus.i_md_ready ? bus.i_md_exception : 1'b1;
          w_rwe     = 1'b1;
          w_val_sel = 2'b11;
          w_pc_en   = 1'b1;
          if (w_exc) begin
            w_dest_sel = 2'b10;
            w_status   = r_is_mul ? STATUS_W'(4) : STATUS_W'(5);
          end
        end
      end
      S_MD_WB: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    w_ready = (w_state == S_IDLE) || (w_state == S_EXEC);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ready    <= 1'b0;
      r_rwe      <= 1'b0;
      r_dest_sel <= 2'b00;
      r_val_sel  <= 2'b00;
      r_alu_sei  <= 1'b0;
      r_alu_op   <= '0;
      r_dmwe     <= 1'b0;
      r_pc_sel   <= 2'b00;
      r_pc_en    <= 1'b0;
      r_md_mult  <= 1'b0;
      r_md_div   <= 1'b0;
      r_status   <= '0;
      r_ovf_code <= 2'd0;
      r_br_ne    <= 1'b0;
      r_br_lt    <= 1'b0;
      r_is_mul   <= 1'b0;
      r_cnt      <= '0;
`ifdef MC_CONTROL_BEX_SETX_EN
      r_bex      <= 1'b0;
`endif
    end else begin
      r_ready    <= w_ready;
      r_rwe      <= w_rwe;
      r_dest_sel <= w_dest_sel;
      r_val_sel  <= w_val_sel;
      r_alu_sei  <= w_alu_sei;
      r_alu_op   <= w_alu_op;
      r_dmwe     <= w_dmwe;
      r_pc_sel   <= w_pc_sel;
      r_pc_en    <= w_pc_en;
      r_md_mult  <= w_md_mult;
      r_md_div   <= w_md_div;
      r_status   <= w_status;
      r_ovf_code <= w_ovf_code;
      r_br_ne    <= w_br_ne;
      r_br_lt    <= w_br_lt;
      r_is_mul   <= w_is_mul;
      r_cnt      <= w_cnt;
`ifdef MC_CONTROL_BEX_SETX_EN
      r_bex      <= w_bex;
`endif
    end
  end

  // ALU flags belong to the op being executed, so they only act during EXEC.
  assign w_in_exec  = (r_state == S_EXEC);
  assign w_ovf      = w_in_exec & bus.i_alu_ovf & (r_ovf_code != 2'd0);
  assign w_br_taken = w_in_exec & ((r_br_ne & bus.i_alu_ne) | (r_br_lt & bus.i_alu_lt));
`ifdef MC_CONTROL_BEX_SETX_EN
  assign w_bex_taken = w_in_exec & r_bex & bus.i_alu_ne;
`else
  assign w_bex_taken = 1'b0;
`endif

  assign bus.o_instr_ready = r_ready;
  assign bus.o_rwe         = r_rwe;
  assign bus.o_dest_sel    = w_ovf ? 2'b10 : r_dest_sel;
  assign bus.o_val_sel     = r_val_sel;
  assign bus.o_alu_sei     = r_alu_sei;
  assign bus.o_alu_op_out  = r_alu_op;
  assign bus.o_dmwe        = r_dmwe;
  assign bus.o_pc_sel      = w_br_taken ? 2'b01 : (w_bex_taken ? 2'b10 : r_pc_sel);
  assign bus.o_pc_en       = r_pc_en;
  assign bus.o_md_mult     = r_md_mult;
  assign bus.o_md_div      = r_md_div;
  assign bus.o_status_val  = w_ovf ? STATUS_W'(r_ovf_code) : r_status;
endmodule

// File: tb/tb_mc_control.sv
// Directed plus randomized bench for mc_control against a per-instruction reference model.
module tb_mc_control;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_if #(.OPCODE_W(5), .ALUOP_W(5), .STATUS_W(32)) bus ();
  mc_control #(.OPCODE_W(5), .ALUOP_W(5), .STATUS_W(32), .MD_TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic        rdy;
    logic        rwe;
    logic [1:0]  dest;
    logic [1:0]  val;
    logic        sei;
    logic [4:0]  aop;
    logic        dmwe;
    logic [1:0]  pcs;
    logic        pcen;
    logic        mult;
    logic        div;
    logic [31:0] st;
  } outs_t;

  int nerr = 0;
  int nchk = 0;
  bit pend_v = 1'b0;
  int pend_op = 0;
  int pend_aop = 0;
`ifdef MC_CONTROL_BEX_SETX_EN
  logic [26:0] pend_tgt = '0;
`endif
  int ops [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22, 9, 13, 31};

  function automatic outs_t sample();
    outs_t o;
    o.rdy  = bus.o_instr_ready;
    o.rwe  = bus.o_rwe;
    o.dest = bus.o_dest_sel;
    o.val  = bus.o_val_sel;
    o.sei  = bus.o_alu_sei;
    o.aop  = bus.o_alu_op_out;
    o.dmwe = bus.o_dmwe;
    o.pcs  = bus.o_pc_sel;
    o.pcen = bus.o_pc_en;
    o.mult = bus.o_md_mult;
    o.div  = bus.o_md_div;
    o.st   = bus.o_status_val;
    return o;
  endfunction

  function automatic outs_t idle_o();
    outs_t o = '0;
    o.rdy = 1'b1;
    return o;
  endfunction

  // Expected outputs in the EXEC cycle of a single-cycle instruction.
  function automatic outs_t exp_exec(input int op, input int aop, input bit ovf, input bit ne, input bit lt);
    outs_t o = '0;
    o.rdy  = 1'b1;
    o.pcen = 1'b1;
    case (op)
      0: begin
        o.rwe = 1'b1;
        o.aop = 5'(aop);
        if (ovf && aop == 0) begin o.dest = 2'b10; o.st = 32'd1; end
        if (ovf && aop == 1) begin o.dest = 2'b10; o.st = 32'd3; end
      end
      1: o.pcs = 2'b10;
      2: o.pcs = ne ? 2'b01 : 2'b00;
      3: begin o.rwe = 1'b1; o.dest = 2'b01; o.val = 2'b10; o.pcs = 2'b10; end
      4: o.pcs = 2'b11;
      5: begin
        o.rwe = 1'b1; o.sei = 1'b1;
        if (ovf) begin o.dest = 2'b10; o.st = 32'd2; end
      end
      6: o.pcs = lt ? 2'b01 : 2'b00;
      7: begin o.sei = 1'b1; o.dmwe = 1'b1; end
      8: begin o.rwe = 1'b1; o.val = 2'b01; o.sei = 1'b1; end
`ifdef MC_CONTROL_BEX_SETX_EN
      21: begin o.rwe = 1'b1; o.dest = 2'b10; o.val = 2'b10; o.st = 32'(pend_tgt); end
      22: o.pcs = ne ? 2'b10 : 2'b00;
`endif
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input outs_t exp);
    outs_t obs;
    obs = sample();
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_pend(input bit ovf, input bit ne, input bit lt);
    if (pend_v) check($sformatf("exec_op%0d_a%0d", pend_op, pend_aop), exp_exec(pend_op, pend_aop, ovf, ne, lt));
    else        check("idle", idle_o());
  endtask

  task automatic drive_flags(input bit ovf, input bit ne, input bit lt);
    bus.i_alu_ovf      = ovf;
    bus.i_alu_ne       = ne;
    bus.i_alu_lt       = lt;
    bus.i_md_ready     = 1'b0;
    bus.i_md_exception = 1'($urandom_range(0, 1));
  endtask

  // One cycle: flags apply to the instruction now in EXEC, fields present the next one.
  task automatic step_simple(input bit v, input int op, input int aop, input bit ovf, input bit ne, input bit lt);
    #1;
    drive_flags(ovf, ne, lt);
    bus.i_instr_valid = v;
    bus.i_opcode      = 5'(op);
    bus.i_aluop       = 5'(aop);
`ifdef MC_CONTROL_BEX_SETX_EN
    bus.i_target      = 27'($urandom);
`endif
    @(negedge clk);
    check_pend(ovf, ne, lt);
    @(posedge clk);
    pend_v   = v;
    pend_op  = op;
    pend_aop = aop;
`ifdef MC_CONTROL_BEX_SETX_EN
    pend_tgt = bus.i_target;
`endif
  endtask

  // Issue mul/div; md_ready pulses in wait cycle d (never if d > T); reset in wait cycle rst_at.
  task automatic step_md(input bit mul, input int d, input bit exc, input int rst_at);
    bit ovf, ne, lt, e, aborted;
    int w;
    outs_t o;
    ovf = 1'($urandom_range(0, 1)); ne = 1'($urandom_range(0, 1)); lt = 1'($urandom_range(0, 1));
    #1;
    drive_flags(ovf, ne, lt);
    bus.i_instr_valid = 1'b1;
    bus.i_opcode      = 5'd0;
    bus.i_aluop       = mul ? 5'd6 : 5'd7;
    @(negedge clk);
    check_pend(ovf, ne, lt);
    @(posedge clk);
    pend_v = 1'b0;
    #1;
    bus.i_opcode = 5'(ops[$urandom_range(0, 13)]);
    bus.i_aluop  = 5'($urandom_range(0, 5));
    @(negedge clk);
    o = '0; o.mult = mul; o.div = !mul;
    check("md_start", o);
    @(posedge clk);
    w = (d <= T) ? d : T;
    e = (d <= T) ? exc : 1'b1;
    aborted = 1'b0;
    for (int k = 1; k <= w; k++) begin
      #1;
      bus.i_md_ready     = (k == d);
      bus.i_md_exception = (k == d) ? exc : 1'($urandom_range(0, 1));
      if (k == rst_at) begin
        #2 rst = 1'b1;
        #1 check("rst_md_wait", '0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_instr_valid = 1'b0;
        bus.i_md_ready    = 1'b0;
        @(posedge clk);
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      check($sformatf("md_wait%0d", k), '0);
      @(posedge clk);
    end
    if (!aborted) begin
      #1;
      bus.i_md_ready    = 1'b0;
      bus.i_instr_valid = 1'b0;
      @(negedge clk);
      o = '0; o.rwe = 1'b1; o.val = 2'b11; o.pcen = 1'b1;
      if (e) begin o.dest = 2'b10; o.st = mul ? 32'd4 : 32'd5; end
      check($sformatf("md_wb_%s_d%0d", mul ? "mul" : "div", d), o);
      @(posedge clk);
    end
  endtask

  initial begin
    int r, op, a;
    bus.i_instr_valid = 1'b0; bus.i_opcode = '0; bus.i_aluop = '0;
    bus.i_alu_ovf = 1'b0; bus.i_alu_ne = 1'b0; bus.i_alu_lt = 1'b0;
    bus.i_md_ready = 1'b0; bus.i_md_exception = 1'b0;
`ifdef MC_CONTROL_BEX_SETX_EN
    bus.i_target = '0;
`endif
    #2 check("rst_init", '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);

    // jal in EXEC, then reset mid-cycle must clear everything asynchronously
    step_simple(1, 3, 0, 0, 0, 0);
    #3 rst = 1'b1;
    #1 check("rst_async", '0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_instr_valid = 1'b0;
    @(posedge clk);
    pend_v = 1'b0;

    // addi with overflow
    step_simple(1, 5, 0, 0, 0, 0);
    step_simple(0, 0, 0, 1, 0, 0);
    // bne not-taken then taken, back to back
    step_simple(1, 2, 0, 0, 0, 0);
    step_simple(1, 2, 0, 0, 0, 0);
    step_simple(0, 0, 0, 0, 1, 0);
    // mul with late exception, div timeout, result exactly at timeout
    step_md(1, 5, 1, 0);
    step_md(0, 99, 0, 0);
    step_md(1, T, 0, 0);
    step_md(0, T, 1, 0);
    // reset during MD_WAIT, then jal
    step_md(0, 99, 0, 3);
    step_simple(1, 3, 0, 0, 0, 0);
    step_simple(0, 0, 0, 0, 0, 0);

    repeat (120) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        step_md(1'($urandom_range(0, 1)), $urandom_range(1, T + 3), 1'($urandom_range(0, 1)), 0);
      end else begin
        op = ops[$urandom_range(0, 13)];
        a  = $urandom_range(0, 31);
        if (a == 6 || a == 7) a = a - 6;
        step_simple(r > 2, op, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    step_simple(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: errors=%0d checks=%0d", nerr, nchk);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle successor to the single-cycle opcode decoder in the processor core.
- Accepts one decoded instruction per handshake and drives registered datapath controls.
- Sequences mult/div through the multdiv unit with stall, timeout and exception handling.
- Resolves branch-taken internally, so the PC mux select is final.

Parameters:
OPCODE_W, 5, opcode field width
ALUOP_W, 5, ALU op field width
STATUS_W, 32, width of exception status value written to rstatus
MD_TIMEOUT, 40, max cycles in MD_WAIT before forced exception (>=1)

Ports:
clock  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction fields valid
opcode  in  OPCODE_W  instruction opcode
aluop  in  ALUOP_W  ALU op field (R-type)
alu_ovf  in  1  ALU overflow for the issued op
alu_ne  in  1  ALU operands not equal
alu_lt  in  1  ALU operand A < B
md_ready  in  1  multdiv result valid
md_exception  in  1  multdiv exception, qualified by md_ready
instr_ready  out  1  block can accept an instruction this cycle
rwe  out  1  regfile write enable
dest_sel  out  2  00 rd, 01 r31, 10 r30
val_sel  out  2  00 ALU, 01 DMEM, 10 PC+1, 11 multdiv result
alu_sei  out  1  ALU B = sign-extended immediate
alu_op_out  out  ALUOP_W  op to ALU (zero for addi/lw/sw)
dmwe  out  1  data memory write enable
pc_sel  out  2  00 PC+1, 01 PC+1+imm, 10 target, 11 rd value
pc_en  out  1  PC register update enable
md_mult  out  1  one-cycle multiply start
md_div  out  1  one-cycle divide start
status_val  out  STATUS_W  value written on exception

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0, including instr_ready; timeout counter cleared.
- Opcode map: 0 R-type, 1 j, 2 bne, 3 jal, 4 jr, 5 addi, 6 blt, 7 sw, 8 lw, 21 setx, 22 bex.
- R-type aluop 6 is mul; aluop 7 is div.
- Any other opcode is a nop: EXEC cycle with rwe=dmwe=0, pc_sel=00, pc_en=1.
- Accept condition: instr_valid & instr_ready. instr_ready=1 in IDLE and EXEC, 0 otherwise.
- States: IDLE, EXEC, MD_START, MD_WAIT, MD_WB.
- Accept of non-mul/div goes to EXEC. EXEC with no new accept goes to IDLE; a new accept allows back-to-back EXEC.
- Accept of mul/div: MD_START (1 cycle), then MD_WAIT, then MD_WB (1 cycle), then IDLE.
- Latency: controls are registered at accept and asserted the following cycle, for exactly one cycle.
- Outside EXEC and MD_WB: rwe=dmwe=pc_en=0.
- EXEC decode:
  - rwe = R-type|lw|jal|addi.
  - dest_sel = 01 on jal.
  - val_sel: 01 on lw, 10 on jal.
  - alu_sei = addi|lw|sw.
  - dmwe = sw.
  - pc_sel: 10 for j/jal, 11 for jr.
  - pc_sel 01 only when (bne & alu_ne) | (blt & alu_lt); otherwise 00.
- EXEC overflow, combinational from alu_ovf in the EXEC cycle:
  - add (aluop 0): dest_sel=10, status_val=1.
  - addi: dest_sel=10, status_val=2.
  - sub (aluop 1): dest_sel=10, status_val=3.
  - No overflow: status_val=0.
- MD_START: md_mult or md_div =1 for one cycle; pc_en=0.
- MD_WAIT: counter increments each cycle.
  - On md_ready: go to MD_WB.
  - When counter reaches MD_TIMEOUT: go to MD_WB with a forced exception.
- MD_WB: rwe=1, val_sel=11, pc_en=1.
  - No exception: dest_sel=00.
  - Exception: dest_sel=10, status_val = 4 (mul) or 5 (div).
- Simultaneous events: md_ready in the same cycle the timeout is reached means md_ready wins.
- instr_valid is ignored while instr_ready=0; the upstream stage holds the instruction.
- Reset mid-MD: immediate IDLE, no write, no start pulse.

Optional Feature:
- Macro: MC_CONTROL_BEX_SETX_EN.
- Defined:
  - setx: EXEC rwe=1, dest_sel=10, val_sel=10 reinterpreted as immediate target, status_val = zero-extended target.
  - bex: pc_sel=10 when alu_ne (r30 != 0), else 00.
- Undefined: opcodes 21/22 decode as nop.

Test Plan:
- Reset asserted mid-cycle -> all outputs 0 asynchronously; after release instr_ready=1, state IDLE.
- Accept addi with alu_ovf=1 -> next cycle rwe=1, alu_sei=1, alu_op_out=0, dest_sel=10, status_val=2, pc_en=1.
- bne with alu_ne=0, then bne with alu_ne=1, back-to-back -> pc_sel 00 then 01; instr_ready held 1.
- mul accept, md_ready after 5 cycles, md_exception=1 -> md_mult one pulse; instr_ready=0 for 7 cycles; MD_WB has rwe=1, dest_sel=10, status_val=4.
- div with md_ready never asserted, MD_TIMEOUT=8 -> MD_WB after 8 wait cycles, dest_sel=10, status_val=5, then IDLE.
- Reset during MD_WAIT, then jal -> no regfile write from the div; jal gives rwe=1, dest_sel=01, val_sel=10, pc_sel=10.
